stack_ctrl: RTL

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/stack_ctrl.sv
// stack_ctrl: call/return/interrupt sequencer for an external return-address
// stack. One request is accepted at a time from IDLE, walks through a single
// PUSH or POP cycle, then a LOAD cycle that hands the new PC to the fetch unit.
// Requests that would overflow or underflow the stack are rejected from IDLE
// with a one-cycle ack+err pulse and a sticky flag.
module stack_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 12,
    localparam int DW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          int_req_i,
    input  logic          reti_req_i,
    input  logic          ret_req_i,
    input  logic          jsb_req_i,
    input  logic [AW-1:0] pc_i,
    input  logic [AW-1:0] tgt_i,
    input  logic [AW-1:0] int_vec_i,
    input  logic [AW-1:0] stk_top_i,
    output logic          push_o,
    output logic          pop_o,
    output logic [AW-1:0] stk_pc_o,
    output logic          pc_load_o,
    output logic [AW-1:0] pc_next_o,
    output logic          ack_o,
    output logic          err_o,
    output logic          ovf_o,
    output logic          unf_o,
    output logic [DW-1:0] depth_o,
    output logic          int_en_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_PUSH, S_POP, S_LOAD} state_e;
    typedef enum logic [1:0] {OP_INT, OP_RETI, OP_RET, OP_JSB} op_e;

    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] tgt_q, tgt_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          int_en_q, int_en_d;
    logic          rej_q, rej_d;

    op_e  sel_op;
    logic sel_vld;
    logic sel_push;

    // Fixed-priority arbitration; a masked interrupt falls through to the rest.
    always_comb begin
        sel_vld = 1'b1;
        sel_op  = OP_JSB;
        if (int_req_i && int_en_q) sel_op = OP_INT;
        else if (reti_req_i)       sel_op = OP_RETI;
        else if (ret_req_i)        sel_op = OP_RET;
        else if (jsb_req_i)        sel_op = OP_JSB;
        else                       sel_vld = 1'b0;
        sel_push = (sel_op == OP_INT) || (sel_op == OP_JSB);
    end

    // Next-state logic. Arbitration is blanked during a reject pulse so the
    // still-held request that caused it is not rejected a second time.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        depth_d  = depth_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        int_en_d = int_en_q;
        rej_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_vld && !rej_q) begin
                    if (sel_push ? (depth_q == FULL) : (depth_q == '0)) begin
                        rej_d = 1'b1;
                        if (sel_push) ovf_d = 1'b1;
                        else          unf_d = 1'b1;
                    end else begin
                        op_d    = sel_op;
                        pc_d    = pc_i;
                        tgt_d   = (sel_op == OP_INT) ? int_vec_i : tgt_i;
                        state_d = sel_push ? S_PUSH : S_POP;
                        if (sel_op == OP_INT) int_en_d = 1'b0;
                    end
                end
            end
            S_PUSH: begin
                depth_d = depth_q + 1'b1;
                state_d = S_LOAD;
            end
            S_POP: begin
                depth_d = depth_q - 1'b1;
                // re-enable so int_en_o is already high during reti's LOAD
                if (op_q == OP_RETI) int_en_d = 1'b1;
                state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; everything freezes while cen is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_JSB;
            pc_q     <= '0;
            tgt_q    <= '0;
            depth_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            int_en_q <= 1'b1;
            rej_q    <= 1'b0;
        end else if (cen) begin
            state_q  <= state_d;
            op_q     <= op_d;
            pc_q     <= pc_d;
            tgt_q    <= tgt_d;
            depth_q  <= depth_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            int_en_q <= int_en_d;
            rej_q    <= rej_d;
        end
    end

    // Strobes decode straight from state, so they are mutually exclusive and
    // hold for as long as cen keeps the state frozen.
    always_comb begin
        push_o    = (state_q == S_PUSH);
        pop_o     = (state_q == S_POP);
        pc_load_o = (state_q == S_LOAD);
        stk_pc_o  = pc_q;
        pc_next_o = '0;
        if (state_q == S_LOAD)
            pc_next_o = ((op_q == OP_RET) || (op_q == OP_RETI)) ? stk_top_i : tgt_q;
        ack_o     = (state_q == S_LOAD) || rej_q;
        err_o     = rej_q;
        ovf_o     = ovf_q;
        unf_o     = unf_q;
        depth_o   = depth_q;
        int_en_o  = int_en_q;
        busy_o    = (state_q != S_IDLE);
    end

endmodule
